// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl
//   Command parser sitting behind a UART receiver. It assembles frames of the
//   form A5, CMD, LEN, payload[LEN], CHK (CHK = XOR of CMD, LEN and the
//   payload), then executes register write / read / clear commands. A read
//   answers with two bytes, 5A followed by the register value.
//
//   Ports
//     clk        system clock, rising edge
//     rst        synchronous active-high reset
//     rx_data    received byte, valid on the byte-done cycle
//     rx_state   receiver state (0 IDLE .. 4 STOP); STOP->IDLE marks a byte
//     tx_byte    byte offered to the transmitter
//     tx_valid   offer strobe, held until tx_ready
//     tx_ready   transmitter accept
//     regs_out   four 8-bit command registers, reg N on [8N+7:8N]
//     busy       high while executing or sending a response
//     frame_err  one-cycle pulse per rejected frame or timeout
module uart_cmd_ctrl #(
   parameter int TIMEOUT_CLKS = 27000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic [2:0]  rx_state,
   output logic [7:0]  tx_byte,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [31:0] regs_out,
   output logic        busy,
   output logic        frame_err
);

   localparam int CNT_W = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CLKS - 1);

   typedef enum logic [2:0] {
      S_HDR, S_CMD, S_LEN, S_PAY, S_CHK, S_EXEC, S_RESP0, S_RESP1
   } state_t;

   state_t           state;
   logic [2:0]       prev_rx_state;
   logic [7:0]       cmd_q;
   logic [1:0]       len_q;
   logic             idx_q;
   logic [7:0]       pay0_q;
   logic [7:0]       pay1_q;
   logic [7:0]       chk_q;
   logic [7:0]       resp_q;
   logic [CNT_W-1:0] tmo_q;
   logic [7:0]       regs_q [4];

   logic byte_done;
   logic counting;
   logic tmo_hit;

   // A byte completes when the receiver leaves STOP for IDLE.
   assign byte_done = (prev_rx_state == 3'd4) && (rx_state == 3'd0);
   assign counting  = (state == S_CMD) || (state == S_LEN) ||
                      (state == S_PAY) || (state == S_CHK);
   // A byte arriving on the expiry cycle takes priority over the timeout.
   assign tmo_hit   = counting && (tmo_q == TMO_LAST) && !byte_done;

   assign busy     = (state == S_EXEC) || (state == S_RESP0) || (state == S_RESP1);
   assign regs_out = {regs_q[3], regs_q[2], regs_q[1], regs_q[0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_HDR;
         prev_rx_state <= 3'd0;
         cmd_q         <= 8'h00;
         len_q         <= 2'd0;
         idx_q         <= 1'b0;
         pay0_q        <= 8'h00;
         pay1_q        <= 8'h00;
         chk_q         <= 8'h00;
         resp_q        <= 8'h00;
         tmo_q         <= '0;
         tx_byte       <= 8'h00;
         tx_valid      <= 1'b0;
         frame_err     <= 1'b0;
         for (int i = 0; i < 4; i++) regs_q[i] <= 8'h00;
      end else begin
         prev_rx_state <= rx_state;
         frame_err     <= 1'b0;

         if (byte_done || !counting || tmo_hit) tmo_q <= '0;
         else                                   tmo_q <= tmo_q + CNT_W'(1);

         if (tmo_hit) begin
            frame_err <= 1'b1;
            state     <= S_HDR;
         end else begin
            case (state)
               S_HDR: begin
                  // Anything but a header byte is line noise; ignore it quietly.
                  if (byte_done && rx_data == 8'hA5) state <= S_CMD;
               end
               S_CMD: begin
                  if (byte_done) begin
                     cmd_q <= rx_data;
                     chk_q <= rx_data;
                     state <= S_LEN;
                  end
               end
               S_LEN: begin
                  if (byte_done) begin
                     chk_q <= chk_q ^ rx_data;
                     len_q <= rx_data[1:0];
                     idx_q <= 1'b0;
                     if (rx_data > 8'd2) begin
                        frame_err <= 1'b1;
                        state     <= S_HDR;
                     end else if (rx_data == 8'd0) begin
                        state <= S_CHK;
                     end else begin
                        state <= S_PAY;
                     end
                  end
               end
               S_PAY: begin
                  if (byte_done) begin
                     chk_q <= chk_q ^ rx_data;
                     if (!idx_q) pay0_q <= rx_data;
                     else        pay1_q <= rx_data;
                     idx_q <= 1'b1;
                     if ({1'b0, idx_q} + 2'd1 == len_q) state <= S_CHK;
                  end
               end
               S_CHK: begin
                  if (byte_done) begin
                     if (rx_data != chk_q) begin
                        frame_err <= 1'b1;
                        state     <= S_HDR;
                     end else begin
                        state <= S_EXEC;
                     end
                  end
               end
               S_EXEC: begin
                  state <= S_HDR;
                  if (cmd_q == 8'h01 && len_q == 2'd2 && pay0_q[7:2] == 6'd0) begin
                     regs_q[pay0_q[1:0]] <= pay1_q;
                  end else if (cmd_q == 8'h02 && len_q == 2'd1 && pay0_q[7:2] == 6'd0) begin
                     resp_q   <= regs_q[pay0_q[1:0]];
                     tx_byte  <= 8'h5A;
                     tx_valid <= 1'b1;
                     state    <= S_RESP0;
                  end else if (cmd_q == 8'h03 && len_q == 2'd0) begin
                     for (int i = 0; i < 4; i++) regs_q[i] <= 8'h00;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
               S_RESP0: begin
                  // tx_valid is already high here; tx_byte moves only on accept.
                  if (tx_ready) begin
                     tx_byte <= resp_q;
                     state   <= S_RESP1;
                  end
               end
               S_RESP1: begin
                  if (tx_ready) begin
                     tx_valid <= 1'b0;
                     state    <= S_HDR;
                  end
               end
               default: state <= S_HDR;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
module tb_uart_cmd_ctrl;

   localparam int TMO = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic [2:0]  rx_state = 3'd0;
   logic [7:0]  tx_byte;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [31:0] regs_out;
   logic        busy;
   logic        frame_err;

   uart_cmd_ctrl #(.TIMEOUT_CLKS(TMO)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_state(rx_state),
      .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .regs_out(regs_out), .busy(busy), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int err_cnt = 0;
   logic [7:0] txq [$];
   bit rand_rdy = 1'b0;
   bit force_rdy = 1'b1;

   // Single driver for tx_ready, changed just after the rising edge.
   always @(posedge clk) begin
      #1;
      tx_ready = rand_rdy ? 1'($urandom % 2) : force_rdy;
   end

   // Count error pulses and record every accepted transmit byte.
   always @(negedge clk) begin
      if (frame_err) err_cnt++;
      if (tx_valid && tx_ready) txq.push_back(tx_byte);
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk); rx_state = 3'd3;
      @(negedge clk); rx_state = 3'd4;
      @(negedge clk); rx_state = 3'd0; rx_data = b;
      @(negedge clk);
   endtask

   task automatic send_frame(input logic [63:0] fr, input int n);
      for (int k = 0; k < n; k++) send_byte(fr[63-8*k -: 8]);
   endtask

   task automatic wait_idle(input string nm);
      int k = 0;
      repeat (3) @(negedge clk);
      while (busy && k < 400) begin
         @(negedge clk);
         k++;
      end
      chk({nm, "_idle"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic chk_tx(input string nm, input int ntx, input logic [7:0] rd);
      chk({nm, "_txcount"}, txq.size(), ntx);
      if (ntx == 2 && txq.size() == 2) begin
         chk({nm, "_tx0"}, {24'd0, txq[0]}, 32'h5A);
         chk({nm, "_tx1"}, {24'd0, txq[1]}, {24'd0, rd});
      end
   endtask

   typedef struct {
      logic [63:0] fr;
      int          n;
      logic [31:0] regs;
      int          errs;
      int          ntx;
      logic [7:0]  rd;
   } vec_t;

   vec_t vecs [10];
   logic [7:0] mregs [4];

   initial begin
      int eb;
      int n;
      bit seen;

      vecs[0] = '{64'hA501_0200_FF00_0000, 6, 32'h003C0000, 1, 0, 8'h00};
      vecs[1] = '{64'hA501_0500_0000_0000, 3, 32'h003C0000, 1, 0, 8'h00};
      vecs[2] = '{64'hA507_0007_0000_0000, 4, 32'h003C0000, 1, 0, 8'h00};
      vecs[3] = '{64'hA502_0104_0700_0000, 5, 32'h003C0000, 1, 0, 8'h00};
      vecs[4] = '{64'hA501_0100_0000_0000, 5, 32'h003C0000, 1, 0, 8'h00};
      vecs[5] = '{64'hA501_0200_1112_0000, 6, 32'h003C0011, 0, 0, 8'h00};
      vecs[6] = '{64'h33A5_0102_0380_8000, 7, 32'h803C0011, 0, 0, 8'h00};
      vecs[7] = '{64'hA502_0103_0000_0000, 5, 32'h803C0011, 0, 2, 8'h80};
      vecs[8] = '{64'hA503_0003_0000_0000, 4, 32'h00000000, 0, 0, 8'h00};
      vecs[9] = '{64'hA501_0201_7775_0000, 6, 32'h00007700, 0, 0, 8'h00};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_regs", regs_out, 32'h0);
      chk("rst_txvalid", {31'd0, tx_valid}, 32'd0);
      chk("rst_txbyte", {24'd0, tx_byte}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ferr", {31'd0, frame_err}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Write with exact visibility timing
      eb = err_cnt;
      send_frame(64'hA501_0202_3C3D_0000, 6);
      chk("wr_busy_exec", {31'd0, busy}, 32'd1);
      chk("wr_regs_during_exec", regs_out, 32'h0);
      @(negedge clk);
      chk("wr_regs_after_exec", regs_out, 32'h003C0000);
      chk("wr_busy_after", {31'd0, busy}, 32'd0);
      chk("wr_errs", err_cnt - eb, 0);

      // Read with the transmitter stalled for 10 cycles
      force_rdy = 1'b0;
      repeat (2) @(negedge clk);
      txq.delete();
      send_frame(64'hA502_0102_0100_0000, 5);
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         chk("rd_hold_valid", {31'd0, tx_valid}, 32'd1);
         chk("rd_hold_byte", {24'd0, tx_byte}, 32'h5A);
         @(negedge clk);
      end
      force_rdy = 1'b1;
      wait_idle("rd");
      chk_tx("rd", 2, 8'h3C);
      chk("rd_txvalid_low", {31'd0, tx_valid}, 32'd0);

      // Table of frames applied back to back
      for (int v = 0; v < 10; v++) begin
         eb = err_cnt;
         txq.delete();
         send_frame(vecs[v].fr, vecs[v].n);
         wait_idle($sformatf("vec%0d", v));
         chk($sformatf("vec%0d_regs", v), regs_out, vecs[v].regs);
         chk($sformatf("vec%0d_errs", v), err_cnt - eb, vecs[v].errs);
         chk_tx($sformatf("vec%0d", v), vecs[v].ntx, vecs[v].rd);
      end

      // Reset in the middle of a write frame
      eb = err_cnt;
      txq.delete();
      send_frame(64'hA501_0201_0000_0000, 4);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_regs", regs_out, 32'h0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      send_frame(64'h5554_0000_0000_0000, 2);
      wait_idle("mid_rst_trail");
      chk("mid_rst_trail_regs", regs_out, 32'h0);
      chk("mid_rst_trail_errs", err_cnt - eb, 0);
      chk("mid_rst_trail_tx", txq.size(), 0);
      send_frame(64'hA502_0100_0300_0000, 5);
      wait_idle("mid_rst_read");
      chk_tx("mid_rst_read", 2, 8'h00);

      // Inter-byte timeout
      send_frame(64'hA501_0202_9998_0000, 6);
      wait_idle("tmo_pre");
      chk("tmo_pre_regs", regs_out, 32'h00990000);
      eb = err_cnt;
      send_frame(64'hA501_0000_0000_0000, 2);
      n = 0;
      seen = 1'b0;
      while (!seen && n < TMO + 10) begin
         @(negedge clk);
         n++;
         if (frame_err) seen = 1'b1;
      end
      chk("tmo_fired", {31'd0, seen}, 32'd1);
      chk("tmo_latency", {31'd0, (n >= TMO - 2 && n <= TMO + 2)}, 32'd1);
      repeat (3) @(negedge clk);
      chk("tmo_errs", err_cnt - eb, 1);
      send_frame(64'hA503_0003_0000_0000, 4);
      wait_idle("tmo_clear");
      chk("tmo_clear_regs", regs_out, 32'h0);

      // A byte landing on the expiry cycle beats the timeout
      send_frame(64'hA501_0200_4241_0000, 6);
      wait_idle("race_pre");
      chk("race_pre_regs", regs_out, 32'h00000042);
      eb = err_cnt;
      send_frame(64'hA503_0000_0000_0000, 2);
      repeat (TMO - 4) @(negedge clk);
      send_byte(8'h00);
      send_byte(8'h03);
      wait_idle("race");
      chk("race_errs", err_cnt - eb, 0);
      chk("race_regs", regs_out, 32'h0);

      // Randomized frames against a frame-level model
      for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
      rand_rdy = 1'b1;
      for (int f = 0; f < 60; f++) begin
         logic [7:0] cmd, len, p0, p1, c;
         int exp_err;
         int ntx;
         logic [7:0] rd;
         bit bad;
         exp_err = 0;
         ntx = 0;
         rd = 8'h00;
         eb = err_cnt;
         txq.delete();
         case ($urandom % 8)
            0, 1: begin cmd = 8'h01; len = 8'd2; end
            2, 3: begin cmd = 8'h02; len = 8'd1; end
            4:    begin cmd = 8'h03; len = 8'd0; end
            default: begin cmd = 8'($urandom % 8); len = 8'($urandom % 4); end
         endcase
         p0 = 8'($urandom % 5);
         p1 = 8'($urandom);
         if ($urandom % 6 == 0) send_byte(8'($urandom % 8'hA5));
         send_byte(8'hA5);
         send_byte(cmd);
         send_byte(len);
         if (len > 8'd2) begin
            exp_err = 1;
         end else begin
            c = cmd ^ len;
            if (len >= 8'd1) begin c = c ^ p0; send_byte(p0); end
            if (len == 8'd2) begin c = c ^ p1; send_byte(p1); end
            bad = ($urandom % 8 == 0);
            send_byte(bad ? (c ^ 8'(1 + $urandom % 255)) : c);
            if (bad) exp_err = 1;
            else if (cmd == 8'h01 && len == 8'd2 && p0 <= 8'd3) mregs[p0[1:0]] = p1;
            else if (cmd == 8'h02 && len == 8'd1 && p0 <= 8'd3) begin ntx = 2; rd = mregs[p0[1:0]]; end
            else if (cmd == 8'h03 && len == 8'd0) for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
            else exp_err = 1;
         end
         wait_idle($sformatf("rnd%0d", f));
         chk($sformatf("rnd%0d_regs", f), regs_out, {mregs[3], mregs[2], mregs[1], mregs[0]});
         chk($sformatf("rnd%0d_errs", f), err_cnt - eb, exp_err);
         chk_tx($sformatf("rnd%0d", f), ntx, rd);
      end
      rand_rdy = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 Parameter TIMEOUT_CLKS, default 27000, inter-byte timeout in clk cycles (1 ms at 27 MHz); SHALL be >= 2.
REQ-002 clk  input  1  system clock (27 MHz); every flop SHALL be clocked on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 rx_data  input  8  byte from the UART receiver; valid when a byte completes (REQ-008).
REQ-005 rx_state  input  3  receiver state: 0 IDLE, 1 WAIT_START, 2 START, 3 DATA, 4 STOP.
REQ-006 tx_byte  output  8  byte offered to the UART transmitter; tx_valid  output  1  offer strobe; tx_ready  input  1  transmitter accept.
REQ-007 regs_out  output  32  four 8-bit command registers, reg N on bits [8N+7:8N]; busy  output  1  high in EXEC/RESP0/RESP1; frame_err  output  1  one-cycle error pulse.

Function
REQ-008 Byte-done SHALL be detected as registered previous rx_state == 4 and current rx_state == 0; rx_data SHALL be captured in that same cycle.
REQ-009 Frame format: 0xA5, CMD, LEN, LEN payload bytes, CHK. CHK SHALL equal the XOR of CMD, LEN and all payload bytes.
REQ-010 States: HDR, CMD, LEN, PAY, CHK, EXEC, RESP0, RESP1; reset state HDR.
REQ-011 HDR: on byte 0xA5 -> CMD; any other byte SHALL be discarded silently, with no frame_err.
REQ-012 CMD: store byte, seed checksum with it -> LEN.
REQ-013 LEN: byte > 2 -> frame_err, -> HDR; byte 0 -> CHK; otherwise -> PAY; the byte SHALL be XORed into the checksum.
REQ-014 PAY: store payload[i] (i = 0..1), XOR into checksum; after LEN bytes -> CHK.
REQ-015 CHK: byte != checksum -> frame_err, -> HDR; equal -> EXEC.
REQ-016 EXEC (exactly one cycle):
- CMD 0x01, LEN 2, payload[0] <= 3: reg[payload[0]] <= payload[1], visible on regs_out the cycle after EXEC, -> HDR.
- CMD 0x02, LEN 1, payload[0] <= 3: latch reg[payload[0]] as response, -> RESP0.
- CMD 0x03, LEN 0: clear all four regs, -> HDR.
- Any other CMD/LEN combination or address > 3: frame_err, no register change, -> HDR.
REQ-017 RESP0: tx_valid = 1, tx_byte = 0x5A; on tx_valid && tx_ready -> RESP1. RESP1: tx_byte = latched data; on accept -> HDR.
REQ-018 tx_byte SHALL stay stable while tx_valid is high and not accepted; tx_valid SHALL be 0 in all other states.
REQ-019 Bytes completing in EXEC, RESP0 or RESP1 SHALL be dropped without frame_err.
REQ-020 Timeout counter:
- Cleared on every byte-done and while in HDR.
- Increments in CMD, LEN, PAY and CHK.
- Reaching TIMEOUT_CLKS-1 -> frame_err, -> HDR.
- If a byte-done occurs in the same cycle, the byte SHALL win and the timeout SHALL NOT fire.
REQ-021 frame_err SHALL be high for exactly one cycle per error event.

Reset
REQ-022 rst SHALL, on the next rising edge and regardless of state (including mid-frame or mid-RESP), force: state HDR, regs_out 0x00000000, tx_valid 0, tx_byte 0x00, busy 0, frame_err 0, checksum 0, timeout counter 0, previous rx_state 0.
REQ-023 A frame in progress when rst asserts SHALL be abandoned; no register write and no response SHALL result from it.

Verification
REQ-024 Write: A5 01 02 02 3C 3D -> regs_out = 0x003C0000 one cycle after EXEC; frame_err stays 0.
REQ-025 Read: after REQ-024, send A5 02 01 02 01 with tx_ready held low 10 cycles -> tx_valid=1, tx_byte=5A stable throughout; then accept -> 5A, 3C transmitted; busy falls.
REQ-026 Bad checksum: A5 01 02 00 FF 00 -> single frame_err pulse, regs_out unchanged, next valid frame accepted.
REQ-027 Bad LEN / unknown CMD / address: A5 01 05 and A5 07 00 07 and A5 02 01 04 07 -> one frame_err pulse each, no tx_valid.
REQ-028 Timeout: send A5 01, then idle TIMEOUT_CLKS cycles -> frame_err pulse; a following A5 03 00 03 clears regs to 0.
REQ-029 Reset mid-frame: assert rst after A5 01 02 01 -> state HDR, regs_out 0; trailing bytes 55 54 produce no write and no frame_err.
